// File: rtl/fft_r22sdf_twmul_s3.sv
// Stage-3 twiddle multiplier for the radix-2^2 SDF FFT: ROM addressing, Q9 complex multiply, round/saturate.
// Optional macro FFT_TWMUL_ROUND_EN selects round-half-up before the shift; otherwise the result is truncated.
module fft_r22sdf_twmul_s3 #(
  parameter int DW      = 16,
  parameter int TW      = 10,
  parameter int TW_FRAC = 9
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic signed [DW-1:0] din_re,
  input  logic signed [DW-1:0] din_im,
  input  logic                 din_vld,
  input  logic                 din_sync,
  output logic [3:0]           addr,
  output logic                 addr_vld,
  input  logic signed [TW-1:0] tf_re,
  input  logic signed [TW-1:0] tf_im,
  output logic signed [DW-1:0] dout_re,
  output logic signed [DW-1:0] dout_im,
  output logic                 dout_vld
);

  localparam int PW = DW + TW;
  localparam int SW = PW + 1;
`ifdef FFT_TWMUL_ROUND_EN
  localparam logic [SW-1:0] RND = SW'(1) << (TW_FRAC - 1);
`else
  localparam logic [SW-1:0] RND = '0;
`endif

  logic [3:0]           cnt;
  logic signed [DW-1:0] ar, ai;
  logic                 v1, v2;
  logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [SW-1:0] re_sum, im_sum, re_shf, im_shf;

  // A sync-qualified sample takes index 0 regardless of the counter.
  assign addr     = (din_vld && din_sync) ? 4'd0 : cnt;
  assign addr_vld = din_vld;

  function automatic logic [DW-1:0] sat(input logic signed [SW-1:0] x);
    if (&x[SW-1:DW-1] || ~|x[SW-1:DW-1])
      sat = {x[DW-1], x[DW-2:0]};
    else if (x[SW-1])
      sat = {1'b1, {(DW-1){1'b0}}};
    else
      sat = {1'b0, {(DW-1){1'b1}}};
  endfunction

  always_comb begin
    re_sum = {p_rr[PW-1], p_rr} - {p_ii[PW-1], p_ii} + RND;
    im_sum = {p_ri[PW-1], p_ri} + {p_ir[PW-1], p_ir} + RND;
    re_shf = re_sum >>> TW_FRAC;
    im_shf = im_sum >>> TW_FRAC;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      ar       <= '0;
      ai       <= '0;
      v1       <= 1'b0;
      v2       <= 1'b0;
      p_rr     <= '0;
      p_ii     <= '0;
      p_ri     <= '0;
      p_ir     <= '0;
      dout_re  <= '0;
      dout_im  <= '0;
      dout_vld <= 1'b0;
    end else begin
      if (din_vld) begin
        cnt <= addr + 4'd1;
        ar  <= din_re;
        ai  <= din_im;
      end
      v1 <= din_vld;
      // The ROM output arrives together with the stage-A data.
      if (v1) begin
        p_rr <= PW'(ar) * PW'(tf_re);
        p_ii <= PW'(ai) * PW'(tf_im);
        p_ri <= PW'(ar) * PW'(tf_im);
        p_ir <= PW'(ai) * PW'(tf_re);
      end
      v2 <= v1;
      if (v2) begin
        dout_re <= sat(re_shf);
        dout_im <= sat(im_shf);
      end
      dout_vld <= v2;
    end
  end

endmodule
